pid_speed_controller: RTL and testbench

Fixed-point PID controller that sits directly upstream of the bidirectional PWM generator. On each sample strobe it computes `setpoint − feedback` and runs P, I and D terms with a clamped integrator. It saturates the sum to the PWM's ±4000 range and registers the result as `pid_control_signal`, which drives the PWM block's input directly. It is a multi-cycle datapath under a small FSM, and accepts one sample per 4-cycle computation.

---
 rtl/pid_speed_controller.sv | 162 ++++++++++++++++
 tb/tb_pid_speed_controller.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_speed_controller.sv
// pid_speed_controller: fixed-point PID loop feeding the bidirectional PWM.
// One update per sample strobe, computed over ERR -> MUL -> SUM -> SAT.
module pid_speed_controller #(
  parameter int OUT_LIMIT = 4000,
  parameter int I_LIMIT   = 1000000,
  parameter int FRAC_BITS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_en,
  input  logic signed [15:0] setpoint,
  input  logic signed [15:0] feedback,
  input  logic        [15:0] kp,
  input  logic        [15:0] ki,
  input  logic        [15:0] kd,
  output logic signed [15:0] pid_control_signal,
  output logic               out_valid,
  output logic               busy
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ERR_W  = 17;
  localparam int unsigned DER_W  = 18;
  localparam int unsigned INT_W  = 24;
  localparam int unsigned ISUM_W = 25;
  localparam int unsigned GAIN_W = 17;
  localparam int unsigned PROD_W = 41;
  localparam int unsigned SUM_W  = 43;

  localparam logic signed [ISUM_W-1:0] I_MAX = ISUM_W'(I_LIMIT);
  localparam logic signed [ISUM_W-1:0] I_MIN = -I_MAX;
  localparam logic signed [SUM_W-1:0]  O_MAX = SUM_W'(OUT_LIMIT);
  localparam logic signed [SUM_W-1:0]  O_MIN = -O_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_MUL,
    S_SUM,
    S_SAT
  } state_t;

  state_t state_q;

  // Holding registers captured on the accepted strobe
  logic signed [DATA_W-1:0] sp_q, fb_q;
  logic        [DATA_W-1:0] kp_q, ki_q, kd_q;

  // Pipeline and loop state
  logic signed [ERR_W-1:0]  err_q, prev_err_q;
  logic signed [DER_W-1:0]  deriv_q;
  logic signed [INT_W-1:0]  integ_q;
  logic signed [PROD_W-1:0] p_q, i_q, d_q;
  logic signed [SUM_W-1:0]  sum_q;

  logic signed [ERR_W-1:0]  err_c;
  logic signed [DER_W-1:0]  deriv_c;
  logic signed [ISUM_W-1:0] integ_sum_c;
  logic signed [INT_W-1:0]  integ_clamp_c;
  logic signed [PROD_W-1:0] p_c, i_c, d_c;
  logic signed [SUM_W-1:0]  sum_c, sum_shift_c;
  logic signed [DATA_W-1:0] sat_c;

  // Error, derivative and clamped integrator update
  always_comb begin
    err_c         = ERR_W'(sp_q) - ERR_W'(fb_q);
    deriv_c       = DER_W'(err_c) - DER_W'(prev_err_q);
    integ_sum_c   = ISUM_W'(integ_q) + ISUM_W'(err_c);
    integ_clamp_c = INT_W'(integ_sum_c);
    if (integ_sum_c > I_MAX) begin
      integ_clamp_c = INT_W'(I_MAX);
    end else if (integ_sum_c < I_MIN) begin
      integ_clamp_c = INT_W'(I_MIN);
    end
  end

  // Gain products: unsigned Q8.8 gains zero-extended into signed multiplies
  always_comb begin
    p_c = PROD_W'($signed({1'b0, kp_q})) * PROD_W'(err_q);
    i_c = PROD_W'($signed({1'b0, ki_q})) * PROD_W'(integ_q);
    d_c = PROD_W'($signed({1'b0, kd_q})) * PROD_W'(deriv_q);
  end

  // Term sum, floor shift back to integer units, output saturation
  always_comb begin
    sum_c       = SUM_W'(p_q) + SUM_W'(i_q) + SUM_W'(d_q);
    sum_shift_c = sum_c >>> FRAC_BITS;
    sat_c       = DATA_W'(sum_q);
    if (sum_q > O_MAX) begin
      sat_c = DATA_W'(O_MAX);
    end else if (sum_q < O_MIN) begin
      sat_c = DATA_W'(O_MIN);
    end
  end

  // Sequencer and datapath registers; reset or disable aborts any update in flight
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_q            <= S_IDLE;
      sp_q               <= '0;
      fb_q               <= '0;
      kp_q               <= '0;
      ki_q               <= '0;
      kd_q               <= '0;
      err_q              <= '0;
      prev_err_q         <= '0;
      deriv_q            <= '0;
      integ_q            <= '0;
      p_q                <= '0;
      i_q                <= '0;
      d_q                <= '0;
      sum_q              <= '0;
      pid_control_signal <= '0;
      out_valid          <= 1'b0;
      busy               <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (sample_en) begin
            sp_q    <= setpoint;
            fb_q    <= feedback;
            kp_q    <= kp;
            ki_q    <= ki;
            kd_q    <= kd;
            busy    <= 1'b1;
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          err_q   <= err_c;
          deriv_q <= deriv_c;
          integ_q <= integ_clamp_c;
          state_q <= S_MUL;
        end
        S_MUL: begin
          p_q     <= p_c;
          i_q     <= i_c;
          d_q     <= d_c;
          state_q <= S_SUM;
        end
        S_SUM: begin
          sum_q   <= sum_shift_c;
          state_q <= S_SAT;
        end
        S_SAT: begin
          pid_control_signal <= sat_c;
          prev_err_q         <= err_q;
          out_valid          <= 1'b1;
          busy               <= 1'b0;
          state_q            <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_speed_controller.sv
// tb_pid_speed_controller: directed checks of the PID update pipeline.
module tb_pid_speed_controller;

  logic               clk;
  logic               reset;
  logic               enable;
  logic               sample_en;
  logic signed [15:0] setpoint;
  logic signed [15:0] feedback;
  logic        [15:0] kp, ki, kd;
  logic signed [15:0] pid_control_signal;
  logic               out_valid;
  logic               busy;

  int errors = 0;
  int checks = 0;

  pid_speed_controller dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .sample_en          (sample_en),
    .setpoint           (setpoint),
    .feedback           (feedback),
    .kp                 (kp),
    .ki                 (ki),
    .kd                 (kd),
    .pid_control_signal (pid_control_signal),
    .out_valid          (out_valid),
    .busy               (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe one sample and return the first output seen and its latency (0 = none)
  task automatic run_sample(input logic signed [15:0] sp, input logic signed [15:0] fb,
                            output logic signed [15:0] res, output int lat);
    @(negedge clk);
    setpoint  = sp;
    feedback  = fb;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    lat = 0;
    res = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid && lat == 0) begin
        lat = k;
        res = pid_control_signal;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    enable    = 1'b1;
    sample_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic set_gains(input logic [15:0] p, input logic [15:0] i, input logic [15:0] d);
    @(negedge clk);
    kp = p;
    ki = i;
    kd = d;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pid_control_signal !== 16'sd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%0d valid=%b busy=%b, expected 0 0 0",
               pid_control_signal, out_valid, busy);
    end
  endtask

  task automatic test_proportional();
    logic signed [15:0] res;
    int lat;
    do_reset();
    set_gains(16'd256, 16'd0, 16'd0);
    run_sample(16'sd1000, 16'sd0, res, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL p_latency: got %0d expected 4", lat); end
    checks++;
    if (res !== 16'sd1000) begin errors++; $display("FAIL p_pos: got %0d expected 1000", res); end
    run_sample(16'sd0, 16'sd1000, res, lat);
    checks++;
    if (res !== -16'sd1000) begin errors++; $display("FAIL p_neg: got %0d expected -1000", res); end
  endtask

  task automatic test_busy_timing();
    int busy_hi = 0;
    do_reset();
    set_gains(16'd256, 16'd0, 16'd0);
    @(negedge clk);
    setpoint  = 16'sd10;
    feedback  = 16'sd0;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise: got %b expected 1", busy); end
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b1) busy_hi++;
    end
    checks++;
    if (busy_hi !== 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_window: got high_after_N1..N4=%0d final=%b expected 3 0", busy_hi, busy);
    end
  endtask

  task automatic test_saturation();
    logic signed [15:0] res;
    int lat;
    do_reset();
    set_gains(16'd256, 16'd0, 16'd0);
    run_sample(16'sd5000, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd4000) begin errors++; $display("FAIL sat_pos: got %0d expected 4000", res); end
    run_sample(-16'sd5000, 16'sd0, res, lat);
    checks++;
    if (res !== -16'sd4000) begin errors++; $display("FAIL sat_neg: got %0d expected -4000", res); end
    run_sample(16'sd32767, -16'sd32768, res, lat);
    checks++;
    if (res !== 16'sd4000) begin errors++; $display("FAIL sat_wide_err: got %0d expected 4000", res); end
    run_sample(16'sd4000, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd4000) begin errors++; $display("FAIL sat_exact: got %0d expected 4000", res); end
    run_sample(16'sd4001, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd4000) begin errors++; $display("FAIL sat_plus1: got %0d expected 4000", res); end
    run_sample(-16'sd4000, 16'sd0, res, lat);
    checks++;
    if (res !== -16'sd4000) begin errors++; $display("FAIL sat_exact_neg: got %0d expected -4000", res); end
    run_sample(16'sd3999, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd3999) begin errors++; $display("FAIL sat_below: got %0d expected 3999", res); end
  endtask

  task automatic test_integrator();
    logic signed [15:0] res;
    logic signed [15:0] exp_v;
    int lat;
    do_reset();
    set_gains(16'd0, 16'd256, 16'd0);
    for (int n = 1; n <= 3; n++) begin
      run_sample(16'sd10, 16'sd0, res, lat);
      exp_v = 16'(10 * n);
      checks++;
      if (res !== exp_v) begin errors++; $display("FAIL integ_step%0d: got %0d expected %0d", n, res, exp_v); end
    end
  endtask

  task automatic test_windup();
    logic signed [15:0] res;
    int lat;
    do_reset();
    set_gains(16'd0, 16'd1, 16'd0);
    for (int n = 1; n <= 40; n++) begin
      run_sample(16'sd30000, 16'sd0, res, lat);
      if (n == 20) begin
        checks++;
        if (res !== 16'sd2343) begin errors++; $display("FAIL windup_mid: got %0d expected 2343", res); end
      end
    end
    checks++;
    if (res !== 16'sd3906) begin errors++; $display("FAIL windup_pinned: got %0d expected 3906", res); end
    run_sample(-16'sd30000, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd3789) begin errors++; $display("FAIL windup_recover: got %0d expected 3789", res); end
  endtask

  task automatic test_derivative();
    logic signed [15:0] res;
    int lat;
    do_reset();
    set_gains(16'd0, 16'd0, 16'd256);
    run_sample(16'sd100, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd100) begin errors++; $display("FAIL deriv_first: got %0d expected 100", res); end
    run_sample(16'sd100, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd0) begin errors++; $display("FAIL deriv_flat: got %0d expected 0", res); end
    run_sample(16'sd40, 16'sd0, res, lat);
    checks++;
    if (res !== -16'sd60) begin errors++; $display("FAIL deriv_drop: got %0d expected -60", res); end
  endtask

  task automatic test_rounding();
    logic signed [15:0] res;
    int lat;
    do_reset();
    set_gains(16'd128, 16'd0, 16'd0);
    run_sample(-16'sd3, 16'sd0, res, lat);
    checks++;
    if (res !== -16'sd2) begin errors++; $display("FAIL round_neg: got %0d expected -2", res); end
    run_sample(16'sd3, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd1) begin errors++; $display("FAIL round_pos: got %0d expected 1", res); end
  endtask

  // use_reset=1 aborts with reset, otherwise by dropping enable for one cycle
  task automatic test_abort(input bit use_reset);
    logic signed [15:0] res;
    int lat;
    int vcount = 0;
    do_reset();
    set_gains(16'd256, 16'd256, 16'd256);
    run_sample(16'sd100, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd300) begin errors++; $display("FAIL abort_pre(%0d): got %0d expected 300", use_reset, res); end
    @(negedge clk);
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (use_reset) reset = 1'b1;
    else enable = 1'b0;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) vcount++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (vcount !== 0 || pid_control_signal !== 16'sd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_clear(%0d): got valids=%0d out=%0d busy=%b expected 0 0 0",
               use_reset, vcount, pid_control_signal, busy);
    end
    run_sample(16'sd100, 16'sd0, res, lat);
    checks++;
    if (res !== 16'sd300 || lat !== 4) begin
      errors++;
      $display("FAIL abort_fresh(%0d): got %0d lat %0d expected 300 lat 4", use_reset, res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] res = '0;
    int vcount = 0;
    do_reset();
    set_gains(16'd256, 16'd0, 16'd0);
    @(negedge clk);
    setpoint  = 16'sd500;
    feedback  = 16'sd0;
    sample_en = 1'b1;
    @(posedge clk);
    #1;
    setpoint = 16'sd2000;
    kp       = 16'd512;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (k == 4) sample_en = 1'b0;
      if (out_valid === 1'b1) begin
        vcount++;
        res = pid_control_signal;
      end
    end
    checks++;
    if (vcount !== 1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", vcount); end
    checks++;
    if (res !== 16'sd500) begin errors++; $display("FAIL b2b_value: got %0d expected 500", res); end
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b1;
    sample_en = 1'b0;
    setpoint  = '0;
    feedback  = '0;
    kp        = '0;
    ki        = '0;
    kd        = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_proportional();
    test_busy_timing();
    test_saturation();
    test_integrator();
    test_windup();
    test_derivative();
    test_rounding();
    test_abort(1'b1);
    test_abort(1'b0);
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
